sd_sector_sequencer: RTL and testbench

SD_SECTOR_SEQUENCER -- requirements
Module: sd_sector_sequencer

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_sector_buf.sv | 42 ++++
 rtl/sd_sector_sequencer.sv | 152 +++++++++++++++
 tb/tb_sd_sector_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD sector sequencer.
// Holds the FSM state encoding, the default sector size and the sector-to-byte shift.
package sd_pkg;

    localparam int SECTOR_BYTES_DEF = 512;
    localparam int SECTOR_SHIFT     = 9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE,
        ERR
    } sd_state_t;

endpackage

// File: rtl/sd_sector_buf.sv
// sd_sector_buf: one-write, one-read synchronous sector RAM (SECTOR_BYTES x 8).
// Reads are registered, return the old byte on a same-index write, and give 0 out of range.
module sd_sector_buf
    import sd_pkg::*;
#(
    parameter int SECTOR_BYTES = SECTOR_BYTES_DEF
) (
    input  logic                            iCLK,
    input  logic                            Reset,
    input  logic                            we,
    input  logic [$clog2(SECTOR_BYTES)-1:0] waddr,
    input  logic [7:0]                      wdata,
    input  logic [8:0]                      raddr,
    output logic [7:0]                      rdata
);

    localparam int AW = $clog2(SECTOR_BYTES);

    logic [7:0] mem [SECTOR_BYTES];
    logic       in_range;

    assign in_range = ({1'b0, raddr} < 10'(SECTOR_BYTES));

    // Write port: RAM storage, no reset so it maps onto block memory.
    always_ff @(posedge iCLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, old data wins on a same-cycle write.
    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            rdata <= '0;
        end else if (in_range) begin
            rdata <= mem[raddr[AW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/sd_sector_sequencer.sv
// sd_sector_sequencer: reads one SD sector into a local buffer on a CPU request.
// Optional SD_SEQ_TIMEOUT_EN adds a transfer watchdog that ends in the ERR state.
module sd_sector_sequencer
    import sd_pkg::*;
#(
    parameter int          SECTOR_BYTES   = SECTOR_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        iCLK,
    input  logic        Reset,
    input  logic        req,
    input  logic [22:0] sector,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [8:0]  buf_idx,
    output logic [7:0]  buf_data,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    input  logic        sd_ready,
    input  logic        sd_byte_valid,
    input  logic [7:0]  sd_dout
);

    localparam int            AW   = $clog2(SECTOR_BYTES);
    localparam logic [AW-1:0] LAST = AW'(SECTOR_BYTES - 1);

    if (TIMEOUT_CYCLES < 1 || SECTOR_BYTES < 16 || SECTOR_BYTES > 512 ||
        (SECTOR_BYTES & (SECTOR_BYTES - 1)) != 0) begin : g_param_chk
        $error("sd_sector_sequencer: illegal SECTOR_BYTES or TIMEOUT_CYCLES");
    end

    sd_state_t     state;
    logic [AW-1:0] wcnt;
    logic          wr_en;

    assign wr_en = sd_byte_valid && (state == ISSUE || state == XFER);

`ifdef SD_SEQ_TIMEOUT_EN
    logic [31:0] tcnt;

    // Sequencer FSM with watchdog; timeout takes priority over a late strobe.
    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            tcnt    <= '0;
            sd_rd   <= 1'b0;
            sd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && sd_ready) begin
                        sd_addr <= 32'(sector) << SECTOR_SHIFT;
                        wcnt    <= '0;
                        tcnt    <= '0;
                        error   <= 1'b0;
                        sd_rd   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE, XFER: begin
                    tcnt <= tcnt + 32'd1;
                    if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        wcnt  <= '0;
                        sd_rd <= 1'b0;
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= ERR;
                    end else if (sd_byte_valid) begin
                        sd_rd <= 1'b0;
                        if (wcnt == LAST) begin
                            wcnt  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                            state <= XFER;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign error = 1'b0;

    // Sequencer FSM; without the watchdog a transfer waits for its bytes forever.
    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            sd_rd   <= 1'b0;
            sd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && sd_ready) begin
                        sd_addr <= 32'(sector) << SECTOR_SHIFT;
                        wcnt    <= '0;
                        sd_rd   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE, XFER: begin
                    if (sd_byte_valid) begin
                        sd_rd <= 1'b0;
                        if (wcnt == LAST) begin
                            wcnt  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                            state <= XFER;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    sd_sector_buf #(
        .SECTOR_BYTES(SECTOR_BYTES)
    ) u_buf (
        .iCLK (iCLK),
        .Reset(Reset),
        .we   (wr_en),
        .waddr(wcnt),
        .wdata(sd_dout),
        .raddr(buf_idx),
        .rdata(buf_data)
    );

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// tb_sd_sector_sequencer: directed bench for the SD sector sequencer.
// Build with SD_SEQ_TIMEOUT_EN defined to exercise the watchdog path.
module tb_sd_sector_sequencer;

    logic        iCLK = 1'b0;
    logic        Reset = 1'b0;
    logic        req = 1'b0;
    logic [22:0] sector = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  buf_idx = '0;
    logic [7:0]  buf_data;
    logic        sd_rd;
    logic [31:0] sd_addr;
    logic        sd_ready = 1'b0;
    logic        sd_byte_valid = 1'b0;
    logic [7:0]  sd_dout = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int early  = 0;
    int err_at = 0;

    sd_sector_sequencer #(
        .SECTOR_BYTES  (512),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .iCLK         (iCLK),
        .Reset        (Reset),
        .req          (req),
        .sector       (sector),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .buf_idx      (buf_idx),
        .buf_data     (buf_data),
        .sd_rd        (sd_rd),
        .sd_addr      (sd_addr),
        .sd_ready     (sd_ready),
        .sd_byte_valid(sd_byte_valid),
        .sd_dout      (sd_dout)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        sd_byte_valid = 1'b1;
        sd_dout       = b;
        tick();
        sd_byte_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_addr", sd_addr, 0);
        check("rst_error", error, 0);
        check("rst_bufdata", buf_data, 0);
        Reset = 1'b1;
        tick();

        sd_ready = 1'b0;
        req = 1'b1;
        sector = 23'd3;
        tick();
        req = 1'b0;
        tick();
        check("nrdy_busy", busy, 0);
        check("nrdy_sd_rd", sd_rd, 0);

        sd_ready = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("issue_addr", sd_addr, 32'h600);
        check("issue_sd_rd", sd_rd, 1);
        check("issue_busy", busy, 1);

        for (int i = 0; i < 512; i++) begin
            if (i == 100) begin
                req = 1'b1;
                sector = 23'd7;
            end
            strobe(8'(i));
            req = 1'b0;
            if (i < 511 && done) early++;
            if (i == 0) check("xfer_sd_rd", sd_rd, 0);
            if (i == 100) begin
                check("busy_req_addr", sd_addr, 32'h600);
                check("busy_req_busy", busy, 1);
            end
        end
        check("early_done", early, 0);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        tick();
        check("done_one_cycle", done, 0);

        buf_idx = 9'd5;
        tick();
        check("rd_idx5", buf_data, 8'h05);
        buf_idx = 9'd511;
        tick();
        check("rd_idx511", buf_data, 8'hFF);

        strobe(8'hAA);
        strobe(8'hAA);
        buf_idx = 9'd0;
        tick();
        check("idle_strobe", buf_data, 8'h00);

        sector = 23'd1;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            strobe(8'hC0 ^ 8'(i));
        end
        #2 Reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sd_rd", sd_rd, 0);
        check("arst_addr", sd_addr, 0);
        check("arst_bufdata", buf_data, 0);
        Reset = 1'b1;
        buf_idx = 9'd150;
        tick();
        check("persist_150", buf_data, 8'h96);
        buf_idx = 9'd50;
        tick();
        check("partial_50", buf_data, 8'hF2);

        sector = 23'd2;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("restart_addr", sd_addr, 32'h400);
        for (int j = 0; j < 512; j++) begin
            if (j == 10) buf_idx = 9'd10;
            strobe(8'(j) ^ 8'h5A);
            if (j == 10) check("rw_same_old", buf_data, 8'hCA);
        end
        check("done2", done, 1);
        tick();
        buf_idx = 9'd0;
        tick();
        check("restart_idx0", buf_data, 8'h5A);
        buf_idx = 9'd10;
        tick();
        check("new_idx10", buf_data, 8'h50);
        buf_idx = 9'd100;
        tick();
        check("new_idx100", buf_data, 8'h3E);

        sector = 23'd9;
        req = 1'b1;
        tick();
        req = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 1100 && err_at == 0; k++) begin
            tick();
            if (error) err_at = k;
        end
        check("tmo_cycle", err_at, 1000);
        check("tmo_sd_rd", sd_rd, 0);
        check("tmo_busy", busy, 0);
        tick();
        sector = 23'd4;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("tmo_clear", error, 0);
        check("tmo_rearm", busy, 1);
`else
        repeat (1200) tick();
        check("wait_error", error, 0);
        check("wait_sd_rd", sd_rd, 1);
        check("wait_busy", busy, 1);
        err_at = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
